ncc_ctrl: RTL and testbench

NCC_CTRL -- requirements
Module: ncc_ctrl

---
 rtl/ncc_ctrl.sv | 120 ++++++++++++
 tb/tb_ncc_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ncc_ctrl.sv
// Sequencer for the NCC PE grid: loads descriptors row/column-group wise, streams the
// window, drains the accumulator chain and flags each result with its window offset.
module ncc_ctrl #(
  parameter int ROWS       = 16,
  parameter int COL_GROUPS = 4,
  parameter int WIN_PIXELS = 640,
  parameter int PE_LAT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic                  win_valid,
  output logic                  win_ready,
  output logic                  load_desc,
  output logic [ROWS-1:0]       load_row,
  output logic [COL_GROUPS-1:0] load_col_group,
  output logic                  load_win,
  output logic                  load_acc,
  output logic                  res_valid,
  output logic [((WIN_PIXELS > 1) ? $clog2(WIN_PIXELS) : 1)-1:0] res_index,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (WIN_PIXELS > 1) ? $clog2(WIN_PIXELS) : 1;
  localparam int AW = $clog2(WIN_PIXELS + PE_LAT + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COL_GROUPS > 1) ? $clog2(COL_GROUPS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DESC, S_WIN, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] adv_cnt;
  logic [AW-1:0] adv_next;
  logic          desc_xfer;
  logic          advance;
  logic          last_col;
  logic          last_desc;
  logic          last_pix;
  logic          last_drain;

  assign desc_ready = (state == S_DESC);
  assign win_ready  = (state == S_WIN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  assign desc_xfer = desc_ready && desc_valid;
  assign advance   = (win_ready && win_valid) || (state == S_DRAIN);
  assign adv_next  = adv_cnt + AW'(1);

  assign last_col   = (col == CW'(COL_GROUPS - 1));
  assign last_desc  = last_col && (row == RW'(ROWS - 1));
  assign last_pix   = (adv_cnt == AW'(WIN_PIXELS - 1));
  // Drain ends on advance number WIN_PIXELS+PE_LAT-1, i.e. counter value one below.
  assign last_drain = (adv_cnt == AW'(WIN_PIXELS + PE_LAT - 2));

  assign load_desc      = desc_xfer;
  assign load_row       = desc_xfer ? (ROWS'(1) << row) : '0;
  assign load_col_group = desc_xfer ? (COL_GROUPS'(1) << col) : '0;
  assign load_win       = advance;
  assign load_acc       = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      adv_cnt   <= '0;
      res_valid <= 1'b0;
      res_index <= '0;
    end else begin
      // A result leaves the chain one cycle after the advance that completed it.
      res_valid <= advance && (adv_next >= AW'(PE_LAT));
      if (advance) begin
        adv_cnt <= adv_next;
        if (adv_next >= AW'(PE_LAT))
          res_index <= IW'(adv_next - AW'(PE_LAT));
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_DESC;
            row       <= '0;
            col       <= '0;
            adv_cnt   <= '0;
            res_index <= '0;
          end
        end
        S_DESC: begin
          if (desc_xfer) begin
            if (last_col) begin
              col <= '0;
              row <= last_desc ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_desc)
              state <= S_WIN;
          end
        end
        S_WIN: begin
          if (advance && last_pix)
            state <= (PE_LAT > 1) ? S_DRAIN : S_DONE;
        end
        S_DRAIN: begin
          if (last_drain)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncc_ctrl.sv
// Directed bench for ncc_ctrl: a count-based model of the match sequence is compared
// against every output each cycle, plus literal per-match totals.
module tb_ncc_ctrl;

  localparam int ROWS = 16;
  localparam int CG   = 4;
  localparam int WP   = 640;
  localparam int PL   = 16;
  localparam int IW   = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          desc_valid = 1'b0;
  logic          win_valid = 1'b0;
  logic          desc_ready, win_ready, load_desc, load_win, load_acc;
  logic          res_valid, busy, done;
  logic [ROWS-1:0] load_row;
  logic [CG-1:0]   load_col_group;
  logic [IW-1:0]   res_index;

  ncc_ctrl #(.ROWS(ROWS), .COL_GROUPS(CG), .WIN_PIXELS(WP), .PE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .win_valid(win_valid), .win_ready(win_ready),
    .load_desc(load_desc), .load_row(load_row), .load_col_group(load_col_group),
    .load_win(load_win), .load_acc(load_acc),
    .res_valid(res_valid), .res_index(res_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 descriptors, 2 window, 3 drain, 4 done.
  int phase = 0, desc_n = 0, pix_n = 0, drain_n = 0, k = 0;
  bit pend_v = 1'b0;
  int pend_i = 0;
  bit m_adv, m_dx;
  int cyc = 0, desc_cyc = 0, win_cyc = 0, first_cyc = 0, res_cnt = 0, last_idx = 0;
  int fin_res = 0, fin_last = 0, fin_first = 0, fin_desc = 0, done_total = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_ctrl", {desc_ready, win_ready, load_desc, load_win, load_acc,
                         res_valid, busy, done}, 0);
      check("rst_load_row", load_row, 0);
      check("rst_load_col_group", load_col_group, 0);
      check("rst_res_index", res_index, 0);
      phase  = 0;
      pend_v = 1'b0;
    end else begin
      m_dx  = (phase == 1) && desc_valid;
      m_adv = ((phase == 2) && win_valid) || (phase == 3);
      check("busy", busy, phase != 0);
      check("done", done, phase == 4);
      check("desc_ready", desc_ready, phase == 1);
      check("win_ready", win_ready, phase == 2);
      check("load_desc", load_desc, m_dx);
      check("load_row", load_row, m_dx ? (32'd1 << (desc_n / CG)) : 32'd0);
      check("load_col_group", load_col_group, m_dx ? (32'd1 << (desc_n % CG)) : 32'd0);
      check("load_win", load_win, m_adv);
      check("load_acc", load_acc, m_adv);
      check("res_valid", res_valid, pend_v);
      if (pend_v) check("res_index", res_index, pend_i);

      if (res_valid) begin
        if (res_cnt == 0) first_cyc = cyc;
        res_cnt++;
        last_idx = res_index;
      end
      if (done) begin
        done_total++;
        fin_res   = res_cnt;
        fin_last  = last_idx;
        fin_first = first_cyc - win_cyc;
        fin_desc  = win_cyc - desc_cyc;
      end

      pend_v = m_adv && (k + 1 >= PL);
      pend_i = k + 1 - PL;
      if (m_adv) k++;
      case (phase)
        0: if (start) begin
             phase = 1; desc_n = 0; pix_n = 0; drain_n = 0; k = 0;
             res_cnt = 0; desc_cyc = cyc + 1;
           end
        1: if (m_dx) begin
             desc_n++;
             if (desc_n == ROWS * CG) begin phase = 2; win_cyc = cyc + 1; end
           end
        2: if (m_adv) begin
             pix_n++;
             if (pix_n == WP) phase = (PL > 1) ? 3 : 4;
           end
        3: begin drain_n++; if (drain_n == PL - 1) phase = 4; end
        default: phase = 0;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_win(input int budget);
    int n = 0;
    while (!win_ready && n < budget) begin tick(); n++; end
    check("wait_win_in_budget", n < budget, 1);
  endtask

  task automatic wait_done(input int budget, input bit start_in_done);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    check("wait_done_in_budget", n < budget, 1);
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic match_totals(input string tag, input int exp_desc, input int exp_done);
    check({tag, "_result_count"}, fin_res, 640);
    check({tag, "_last_index"}, fin_last, 639);
    check({tag, "_first_result_delay"}, fin_first, 16);
    check({tag, "_desc_cycles"}, fin_desc, exp_desc);
    check({tag, "_done_total"}, done_total, exp_done);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Match 1: back-to-back words and pixels, extra starts in DESC and DONE.
    start = 1'b1; desc_valid = 1'b1; win_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, 1'b1);
    desc_valid = 1'b0; win_valid = 1'b0;
    repeat (5) tick();
    match_totals("m1", 64, 1);

    // Match 2: alternating descriptor valid, 5-cycle pixel gap mid-stream.
    start = 1'b1;
    tick();
    start = 1'b0; desc_valid = 1'b1;
    for (int n = 0; n < 300 && !win_ready; n++) begin
      tick();
      desc_valid = ~desc_valid;
    end
    desc_valid = 1'b0; win_valid = 1'b1;
    repeat (320) tick();
    win_valid = 1'b0;
    repeat (5) tick();
    win_valid = 1'b1;
    wait_done(3000, 1'b0);
    win_valid = 1'b0;
    repeat (5) tick();
    match_totals("m2", 127, 2);

    // Match 3: reset at window pixel 300 aborts the match.
    start = 1'b1; desc_valid = 1'b1; win_valid = 1'b1;
    tick();
    start = 1'b0;
    wait_win(200);
    repeat (300) tick();
    rst = 1'b1; desc_valid = 1'b0; win_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("m3_no_done_after_abort", done_total, 2);

    // Match 4: fresh match after the abort.
    start = 1'b1; desc_valid = 1'b1; win_valid = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, 1'b0);
    desc_valid = 1'b0; win_valid = 1'b0;
    repeat (5) tick();
    match_totals("m4", 64, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
